// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 2).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  if (WIDTH < 4) begin : g_width_check
    $error("alu_seq: WIDTH must be at least 4");
  end

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_ROL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_XNOR = 4'd12;
  localparam logic [3:0] OP_SLT  = 4'd13;
  localparam logic [3:0] OP_EQ   = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DONE = 1'b1} state_t;
`endif

  state_t state, state_next;

  logic [SHW-1:0]     amt;
  logic [WIDTH:0]     sum_w, diff_w, shl_w, shr_w;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf, alu_err;

  // Shifts are done one bit wider so the last bit shifted out lands in a fixed position.
  assign amt    = SHW'(b[SHW-1:0] % WIDTH);
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign shl_w  = {1'b0, a} << amt;
  assign shr_w  = {a, 1'b0} >> amt;
  assign rol_w  = {a, a} << amt;
  assign ror_w  = {a, a} >> amt;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
`ifndef ALU_SEQ_MUL_EN
      OP_MUL:  alu_err = 1'b1;
`endif
      OP_SHL: begin
        alu_res   = shl_w[WIDTH-1:0];
        alu_carry = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_w[WIDTH:1];
        alu_carry = shr_w[0];
      end
      OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_res = ror_w[WIDTH-1:0];
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_NAND: alu_res = ~(a & b);
      OP_XNOR: alu_res = ~(a ^ b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_EQ:   alu_res = WIDTH'(a == b);
      OP_PASS: alu_res = a;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
          state_next = (op == OP_MUL) ? S_MUL : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   if (cnt == '0) state_next = S_DONE;
`endif
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output register: loaded on acceptance of a single-cycle op or on the final multiply step.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              cnt    <= CW'(WIDTH - 1);
            end else begin
`endif
              result <= alu_res;
              zero   <= (alu_res == '0);
              neg    <= alu_res[WIDTH-1];
              carry  <= alu_carry;
              ovf    <= alu_ovf;
              err    <= alu_err;
`ifdef ALU_SEQ_MUL_EN
            end
`endif
          end
        end
`ifdef ALU_SEQ_MUL_EN
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            result <= acc_next[WIDTH-1:0];
            zero   <= (acc_next[WIDTH-1:0] == '0);
            neg    <= acc_next[WIDTH-1];
            carry  <= 1'b0;
            ovf    <= |acc_next[2*WIDTH-1:WIDTH];
            err    <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule
